nes_input_scheduler: RTL and testbench
======================================

// Module: nes_input_scheduler
// PURPOSE
//   Conditions the eight NES controller buttons and schedules them as discrete events for one consumer at a time.
//   - Debounces the buttons and detects press edges.
//   - Generates auto-repeat for the D-pad.
//   - Tracks an operating mode (VGA colour / clock set / audio) that select cycles through.
//   - Presents one event at a time on a valid/ready port; mode tags each event so the top level routes it.
// PARAMETERS
//   DEBOUNCE_CYCLES  500_000     consecutive stable cycles before a button level is accepted (10 ms @ 50 MHz)
//   REPEAT_DELAY     25_000_000  hold time before first auto-repeat (500 ms)
//   REPEAT_PERIOD    5_000_000   interval between subsequent auto-repeats (100 ms)
// PORTS
//   clock       in   1   system clock, 50 MHz
//   reset_n     in   1   synchronous reset, active low
//   btn_raw     in   8   NesReader levels, 1=pressed: [0]right [1]left [2]down [3]up [4]start [5]select [6]b [7]a
//   btn_stable  out  8   debounced levels, same bit order
//   mode        out  2   0=VGA, 1=CLOCK_SET, 2=AUDIO (3 never produced)
//   evt_valid   out  1   event held on evt_* outputs
//   evt_ready   in   1   consumer accepts event this cycle
//   evt_btn     out  3   button index of event (never 5)
//   evt_dest    out  2   value of mode when the event was captured
//   evt_repeat  out  1   1=auto-repeat event, 0=fresh press
//   overrun     out  1   sticky: an event was lost because its pending bit was already set
// BEHAVIOUR
//   Reset
//   - Applied at a clock edge when reset_n=0; also valid mid-operation.
//   - All outputs go to 0, along with all counters, pending bits and the repeat FSM.
//   - After reset a button already held must re-debounce before it is seen; this yields one fresh press event.
//   Debounce
//   - One counter per button; it clears whenever btn_raw[i]==btn_stable[i].
//   - When btn_raw[i]!=btn_stable[i] the counter increments each cycle.
//   - When the count reaches DEBOUNCE_CYCLES-1, btn_stable[i] toggles on that edge and the counter clears.
//   Press edge
//   - A press is btn_stable[i] 0->1, registered as press[i] one cycle later.
//   - Releases generate no event.
//   Select
//   - press[5] advances mode 0->1->2->0 on the next edge.
//   - It is never queued or emitted.
//   Pending
//   - 8-bit pending mask. Bit i sets on press[i] or on a repeat tick for button i.
//   - If bit i is already set, or is being loaded into the output register that cycle, the new event is
//     coalesced and overrun<=1.
//   - The evt_repeat flag is stored per pending bit.
//   Output register
//   - It is free when evt_valid==0, or when evt_valid&&evt_ready.
//   - When free and pending!=0, the lowest set index loads on the next edge: evt_btn=index, evt_dest=current mode,
//     evt_valid=1, and that pending bit clears.
//   - When free and pending==0, evt_valid<=0.
//   - While evt_valid=1 and evt_ready=0, all evt_* outputs are held stable.
//   - Back-to-back accept gives one event per cycle.
//   - Latency: btn_stable rises at edge N, pending sets at N+1, evt_valid=1 from N+2 when the register is free.
//   Mode change while an event is held
//   - evt_dest keeps its captured value.
//   - Events still pending take the new mode when loaded.
//   Auto-repeat
//   - One shared FSM tracks a single D-pad button (bits 0-3) and runs on btn_stable.
//   - R_IDLE: when any D-pad bit rises, latch its index (lowest wins on a simultaneous rise), clear the timer,
//     go to R_DELAY.
//   - R_DELAY: count to REPEAT_DELAY-1, then emit a repeat tick and go to R_RATE with the timer cleared.
//   - R_RATE: emit a tick every REPEAT_PERIOD cycles.
//   - From any state, when the tracked button's btn_stable falls, go to R_IDLE. A different D-pad bit rising
//     re-latches to it and restarts R_DELAY.
//   - start, b and a never repeat.
//   Widths
//   - Timers are $clog2 of their maximum parameter; they never wrap past their terminal count.
// TESTING (run with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
//   1. Reset with btn_raw=0x00, then raise btn_raw[3] and hold it
//      -> btn_stable[3]=1 after 4 cycles; evt_valid=1, evt_btn=3, evt_dest=0, evt_repeat=0 two cycles later.
//   2. Bounce: toggle btn_raw[7] every 2 cycles for 20 cycles -> btn_stable stays 0x00, evt_valid stays 0.
//   3. Pulse select 3 times, each a clean press and release -> mode goes 1, 2, 0; no event emitted.
//   4. Raise bits 0, 4 and 6 together with evt_ready=1
//      -> events with evt_btn 0, 4, 6 on consecutive cycles; overrun=0.
//   5. Hold up with evt_ready=1
//      -> fresh event, then repeat events (evt_repeat=1) 20 cycles after btn_stable rise and every 8 cycles after;
//         none after release.
//   6. Hold evt_ready=0 with an event held, press b twice, then reset_n=0 for 1 cycle
//      -> evt_* stable and overrun=1 before reset; all outputs 0 after.

Source files
------------

// File: rtl/nes_input_scheduler.sv
// NES button conditioner: per-button debounce, press edges, shared D-pad auto-repeat,
// select-driven mode tracking and a one-deep valid/ready event port fed from a pending mask.
module nes_input_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] btn_raw,
    output logic [7:0] btn_stable,
    output logic [1:0] mode,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_btn,
    output logic [1:0] evt_dest,
    output logic       evt_repeat,
    output logic       overrun
);
    localparam int unsigned NUM_BTN = 8;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RT_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RT_W-1:0] DELAY_LAST  = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0] PERIOD_LAST = RT_W'(REPEAT_PERIOD - 1);
    localparam logic [7:0]      EVENT_MASK  = 8'hDF; // select only steers mode

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RATE} repState_t;

    logic [DB_W-1:0] dbCnt [NUM_BTN];
    logic [7:0]      stableQ;
    logic [7:0]      riseC;
    logic [3:0]      dpadStableC;
    logic [3:0]      dpadRiseC;
    logic [1:0]      riseIdxC;
    repState_t       repState;
    logic [1:0]      trkIdx;
    logic [RT_W-1:0] repTimer;
    logic            tickC;
    logic [7:0]      tickVecC;
    logic [7:0]      newEvtC;
    logic [7:0]      setMaskC;
    logic [7:0]      loadMaskC;
    logic [7:0]      pending;
    logic [7:0]      pendRep;
    logic [2:0]      selIdxC;
    logic            freeC;

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                dbCnt[i] <= '0;
            end
            btn_stable <= '0;
            stableQ    <= '0;
        end else begin
            stableQ <= btn_stable;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (btn_raw[i] == btn_stable[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    dbCnt[i]      <= '0;
                    btn_stable[i] <= ~btn_stable[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign riseC       = btn_stable & ~stableQ;
    assign dpadStableC = btn_stable[3:0];
    assign dpadRiseC   = riseC[3:0];

    always_comb begin
        riseIdxC = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (dpadRiseC[i]) riseIdxC = 2'(i);
        end
    end

    // A tick is suppressed once the tracked button has dropped, before the FSM returns to idle
    always_comb begin
        tickC = 1'b0;
        case (repState)
            R_DELAY: tickC = (repTimer == DELAY_LAST);
            R_RATE:  tickC = (repTimer == PERIOD_LAST);
            default: tickC = 1'b0;
        endcase
        tickC = tickC & dpadStableC[trkIdx];
    end

    assign tickVecC = tickC ? (8'd1 << trkIdx) : 8'd0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            repState <= R_IDLE;
            trkIdx   <= '0;
            repTimer <= '0;
        end else if (|dpadRiseC) begin
            repState <= R_DELAY;
            trkIdx   <= riseIdxC;
            repTimer <= '0;
        end else if ((repState != R_IDLE) && !dpadStableC[trkIdx]) begin
            repState <= R_IDLE;
            repTimer <= '0;
        end else begin
            case (repState)
                R_DELAY: begin
                    if (repTimer == DELAY_LAST) begin
                        repState <= R_RATE;
                        repTimer <= '0;
                    end else begin
                        repTimer <= repTimer + RT_W'(1);
                    end
                end
                R_RATE: begin
                    if (repTimer == PERIOD_LAST) repTimer <= '0;
                    else                         repTimer <= repTimer + RT_W'(1);
                end
                default: repTimer <= '0;
            endcase
        end
    end

    assign freeC = !evt_valid || evt_ready;

    always_comb begin
        selIdxC = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) selIdxC = 3'(i);
        end
    end

    assign loadMaskC = (freeC && (|pending)) ? (8'd1 << selIdxC) : 8'd0;
    assign newEvtC   = (riseC & EVENT_MASK) | tickVecC;
    assign setMaskC  = newEvtC & ~pending;

    // Pending mask, output register and mode; an event hitting an occupied pending bit is dropped
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending    <= '0;
            pendRep    <= '0;
            overrun    <= 1'b0;
            evt_valid  <= 1'b0;
            evt_btn    <= '0;
            evt_dest   <= '0;
            evt_repeat <= 1'b0;
            mode       <= '0;
        end else begin
            pending <= (pending & ~loadMaskC) | setMaskC;
            pendRep <= (pendRep & ~setMaskC) | (tickVecC & setMaskC);
            if (|(newEvtC & pending)) overrun <= 1'b1;
            if (freeC) begin
                if (|pending) begin
                    evt_valid  <= 1'b1;
                    evt_btn    <= selIdxC;
                    evt_dest   <= mode;
                    evt_repeat <= pendRep[selIdxC];
                end else begin
                    evt_valid <= 1'b0;
                end
            end
            if (riseC[5]) mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
        end
    end

endmodule

// File: tb/tb_nes_input_scheduler.sv
// Bench for nes_input_scheduler: directed scenarios plus randomized buttons/ready/reset
// checked against a cycle-level reference model built from the behavioural rules.
module tb_nes_input_scheduler;
    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clock;
    logic       reset_n;
    logic [7:0] btn_raw;
    logic [7:0] btn_stable;
    logic [1:0] mode;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_btn;
    logic [1:0] evt_dest;
    logic       evt_repeat;
    logic       overrun;

    int nTests = 0;
    int nFail  = 0;

    int         cyc = 0;
    int         mDiff [8];
    logic [7:0] mStable  = '0;
    logic [7:0] mPrev    = '0;
    logic [7:0] mPend    = '0;
    logic [7:0] mPendRep = '0;
    logic [1:0] mMode    = '0;
    logic       mValid   = 1'b0;
    logic [2:0] mBtn     = '0;
    logic [1:0] mDest    = '0;
    logic       mRep     = 1'b0;
    logic       mOverrun = 1'b0;
    int         mTrk     = -1;
    int         mLatch   = 0;

    nes_input_scheduler #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .btn_stable(btn_stable),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_btn   (evt_btn),
        .evt_dest  (evt_dest),
        .evt_repeat(evt_repeat),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [17:0] dutState();
        return {btn_stable, mode, evt_valid, evt_btn, evt_dest, evt_repeat, overrun};
    endfunction

    function automatic logic [17:0] modelState();
        return {mStable, mMode, mValid, mBtn, mDest, mRep, mOverrun};
    endfunction

    // Model: repeats fall at latch+RD+k*RP while the latched D-pad button stays held
    task automatic modelUpdate();
        logic [7:0] rise;
        logic [7:0] tickVec;
        logic [7:0] newEv;
        logic [7:0] setMask;
        logic       free;
        logic       selRep;
        int         sel;
        cyc++;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) mDiff[i] = 0;
            mStable = '0; mPrev = '0; mPend = '0; mPendRep = '0; mMode = '0;
            mValid = 1'b0; mBtn = '0; mDest = '0; mRep = 1'b0; mOverrun = 1'b0;
            mTrk = -1; mLatch = 0;
        end else begin
            rise    = mStable & ~mPrev;
            tickVec = '0;
            if (mTrk >= 0 && mStable[mTrk] && (cyc - mLatch) >= int'(RD)
                && ((cyc - mLatch - int'(RD)) % int'(RP)) == 0)
                tickVec[mTrk] = 1'b1;
            if (rise[3:0] != 4'd0) begin
                for (int i = 3; i >= 0; i--) if (rise[i]) mTrk = i;
                mLatch = cyc;
            end
            newEv = (rise & 8'hDF) | tickVec;
            free  = !mValid || evt_ready;
            sel   = -1;
            for (int i = 7; i >= 0; i--) if (mPend[i]) sel = i;
            if ((newEv & mPend) != 8'd0) mOverrun = 1'b1;
            setMask = newEv & ~mPend;
            selRep  = (sel >= 0) ? mPendRep[sel] : 1'b0;
            if (free) begin
                if (sel >= 0) begin
                    mValid = 1'b1; mBtn = 3'(sel); mDest = mMode; mRep = selRep;
                    mPend[sel] = 1'b0;
                end else begin
                    mValid = 1'b0;
                end
            end
            mPend    = mPend | setMask;
            mPendRep = (mPendRep & ~setMask) | (tickVec & setMask);
            if (rise[5]) mMode = (mMode == 2'd2) ? 2'd0 : mMode + 2'd1;
            mPrev = mStable;
            for (int i = 0; i < 8; i++) begin
                if (btn_raw[i] != mStable[i]) begin
                    mDiff[i]++;
                    if (mDiff[i] == int'(DB)) begin
                        mStable[i] = ~mStable[i];
                        mDiff[i]   = 0;
                    end
                end else begin
                    mDiff[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        modelUpdate();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; btn_raw = 8'h00; evt_ready = 1'b0;
        step(); step();
        nTests++;
        if (dutState() !== 18'h0) begin
            nFail++; $display("FAIL reset_outputs: got %h, expected %h", dutState(), 18'h0);
        end
        reset_n = 1'b1;
        step();
        nTests++;
        if (dutState() !== modelState()) begin
            nFail++; $display("FAIL reset_model cyc=%0d: got %h, expected %h", cyc, dutState(), modelState());
        end
    endtask

    task automatic test_press();
        evt_ready = 1'b0; btn_raw = 8'h08;
        for (int t = 1; t <= 6; t++) begin
            step();
            nTests++;
            if (btn_stable[3] !== (t >= 4)) begin
                nFail++; $display("FAIL press_debounce t=%0d: got %b, expected %b", t, btn_stable[3], (t >= 4));
            end
            nTests++;
            if (evt_valid !== (t >= 6)) begin
                nFail++; $display("FAIL press_latency t=%0d: got %b, expected %b", t, evt_valid, (t >= 6));
            end
        end
        nTests++;
        if ({evt_btn, evt_dest, evt_repeat} !== {3'd3, 2'd0, 1'b0}) begin
            nFail++; $display("FAIL press_payload: got btn=%0d dest=%0d rep=%b, expected btn=3 dest=0 rep=0",
                              evt_btn, evt_dest, evt_repeat);
        end
        evt_ready = 1'b1;
        step();
        nTests++;
        if (evt_valid !== 1'b0) begin
            nFail++; $display("FAIL press_drain: got %b, expected 0", evt_valid);
        end
        btn_raw = 8'h00;
        for (int t = 0; t < 8; t++) begin
            step();
            nTests++;
            if (dutState() !== modelState()) begin
                nFail++; $display("FAIL press_model cyc=%0d: got %h, expected %h", cyc, dutState(), modelState());
            end
        end
    endtask

    task automatic test_bounce();
        evt_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k < 20 && (k % 2) == 0) btn_raw[7] = ~btn_raw[7];
            step();
            nTests++;
            if (btn_stable !== 8'h00 || evt_valid !== 1'b0) begin
                nFail++; $display("FAIL bounce k=%0d: got stable=%h valid=%b, expected stable=00 valid=0",
                                  k, btn_stable, evt_valid);
            end
        end
    endtask

    task automatic test_select();
        for (int p = 1; p <= 3; p++) begin
            for (int ph = 0; ph < 12; ph++) begin
                btn_raw = (ph < 6) ? 8'h20 : 8'h00;
                step();
                nTests++;
                if (evt_valid !== 1'b0) begin
                    nFail++; $display("FAIL select_no_event p=%0d: got %b, expected 0", p, evt_valid);
                end
            end
            nTests++;
            if (mode !== 2'(p % 3)) begin
                nFail++; $display("FAIL select_mode p=%0d: got %0d, expected %0d", p, mode, p % 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       expV;
        logic [2:0] expB;
        evt_ready = 1'b1; btn_raw = 8'h51;
        for (int t = 1; t <= 12; t++) begin
            step();
            expV = (t >= 6 && t <= 8);
            expB = (t == 6) ? 3'd0 : (t == 7) ? 3'd4 : 3'd6;
            nTests++;
            if (evt_valid !== expV) begin
                nFail++; $display("FAIL b2b_valid t=%0d: got %b, expected %b", t, evt_valid, expV);
            end
            if (expV) begin
                nTests++;
                if (evt_btn !== expB) begin
                    nFail++; $display("FAIL b2b_btn t=%0d: got %0d, expected %0d", t, evt_btn, expB);
                end
            end
        end
        nTests++;
        if (overrun !== 1'b0) begin
            nFail++; $display("FAIL b2b_overrun: got %b, expected 0", overrun);
        end
        btn_raw = 8'h00;
        for (int t = 0; t < 8; t++) begin
            step();
            nTests++;
            if (dutState() !== modelState()) begin
                nFail++; $display("FAIL b2b_model cyc=%0d: got %h, expected %h", cyc, dutState(), modelState());
            end
        end
    endtask

    task automatic test_repeat();
        logic expV;
        evt_ready = 1'b1; btn_raw = 8'h08;
        for (int t = 1; t <= 75; t++) begin
            step();
            expV = (t == 6) || (t >= 26 && t <= 50 && ((t - 26) % 8) == 0);
            nTests++;
            if (evt_valid !== expV) begin
                nFail++; $display("FAIL repeat_valid t=%0d: got %b, expected %b", t, evt_valid, expV);
            end
            if (expV) begin
                nTests++;
                if (evt_btn !== 3'd3 || evt_repeat !== (t != 6)) begin
                    nFail++; $display("FAIL repeat_payload t=%0d: got btn=%0d rep=%b, expected btn=3 rep=%b",
                                      t, evt_btn, evt_repeat, (t != 6));
                end
            end
            nTests++;
            if (dutState() !== modelState()) begin
                nFail++; $display("FAIL repeat_model cyc=%0d: got %h, expected %h", cyc, dutState(), modelState());
            end
            if (t == 52) btn_raw = 8'h00;
        end
    endtask

    task automatic test_hold_overrun();
        logic [7:0] seq [6];
        seq = '{8'h40, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00};
        evt_ready = 1'b0; btn_raw = 8'h80;
        for (int t = 0; t < 6; t++) step();
        for (int ph = -1; ph < 6; ph++) begin
            btn_raw = (ph < 0) ? 8'h00 : seq[ph];
            for (int t = 0; t < 6; t++) begin
                step();
                nTests++;
                if ({evt_valid, evt_btn, evt_dest, evt_repeat} !== {1'b1, 3'd7, 2'd0, 1'b0}) begin
                    nFail++; $display("FAIL hold_stable ph=%0d: got v=%b btn=%0d dest=%0d rep=%b, expected v=1 btn=7 dest=0 rep=0",
                                      ph, evt_valid, evt_btn, evt_dest, evt_repeat);
                end
            end
            if (ph == 1) begin
                nTests++;
                if (overrun !== 1'b0) begin
                    nFail++; $display("FAIL hold_no_overrun: got %b, expected 0", overrun);
                end
            end
            if (ph == 3) begin
                nTests++;
                if (mode !== 2'd1) begin
                    nFail++; $display("FAIL hold_mode: got %0d, expected 1", mode);
                end
            end
        end
        nTests++;
        if (overrun !== 1'b1) begin
            nFail++; $display("FAIL hold_overrun: got %b, expected 1", overrun);
        end
        evt_ready = 1'b1;
        step();
        nTests++;
        if ({evt_valid, evt_btn, evt_dest, evt_repeat} !== {1'b1, 3'd6, 2'd1, 1'b0}) begin
            nFail++; $display("FAIL hold_new_dest: got v=%b btn=%0d dest=%0d rep=%b, expected v=1 btn=6 dest=1 rep=0",
                              evt_valid, evt_btn, evt_dest, evt_repeat);
        end
        evt_ready = 1'b0; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        nTests++;
        if (dutState() !== 18'h0) begin
            nFail++; $display("FAIL hold_reset: got %h, expected %h", dutState(), 18'h0);
        end
    endtask

    task automatic test_random();
        int idx;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = int'($urandom_range(0, 7));
                btn_raw[idx] = ~btn_raw[idx];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            reset_n   = ($urandom_range(0, 399) != 0);
            step();
            nTests++;
            if (dutState() !== modelState()) begin
                nFail++; $display("FAIL random_model cyc=%0d: got %h, expected %h", cyc, dutState(), modelState());
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_select();
        test_back_to_back();
        test_repeat();
        test_hold_overrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
